axis_fifo_prefill_monitor: RTL and testbench
============================================

Name: axis_fifo_prefill_monitor

Overview:
- Write-side companion to the TX FIFO read controller; sits between the upstream AXIS source and the TX FIFO write port.
- Tracks FIFO occupancy and the fill of the current frame.
- Raises fifo_min_data_write_done once enough of a frame is buffered (MIN_FILL words, frame end, or write stall), so the read side can start without underrun.
- Holds done until the frame has fully drained.

Parameters:
- DEPTH_LOG2, 5: FIFO depth = 2**DEPTH_LOG2 words.
- MIN_FILL, 8: accepted words of a frame required before done; legal range 1..2**DEPTH_LOG2.
- STALL_CYCLES, 16: consecutive write-idle cycles in FILL that force done; range 1..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  upstream beat valid; also the FIFO write strobe source.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  combinational, = ~fifo_full.
- fifo_rd_enable  in  1  read strobe issued by the read controller.
- fifo_wr_en  out  1  combinational, = s_axis_tvalid & s_axis_tready.
- fifo_min_data_write_done  out  1  registered, high in READY.
- fifo_level  out  DEPTH_LOG2+1  registered occupancy.
- fifo_full  out  1  combinational, level == 2**DEPTH_LOG2.
- fifo_empty  out  1  combinational, level == 0.
- clear_sticky  in  1  synchronous clear of both sticky flags.
- overflow_sticky  out  1  set on s_axis_tvalid while fifo_full.
- underflow_sticky  out  1  set on fifo_rd_enable while fifo_empty.

Behaviour:
- Reset (async assert, sync release): state=IDLE; level=0; frame_cnt=0; stall_cnt=0; last_seen=0; done=0; both sticky flags=0. Combinational outputs follow: tready=1, full=0, empty=1.
- Definitions: wr = fifo_wr_en; rd = fifo_rd_enable & ~fifo_empty.
- Level update: level <= level + wr - rd.
  - wr and rd in the same cycle: level unchanged.
  - rd while empty: ignored, underflow_sticky set.
  - tvalid while full: beat rejected (tready=0), overflow_sticky set.
- Sticky flags: set has priority over clear_sticky in the same cycle.
- frame_cnt: DEPTH_LOG2+1 bits, saturates at MIN_FILL.
- stall_cnt: 8 bits; reset to 0 on any wr, saturates at STALL_CYCLES.
- State IDLE: done=0.
  - On wr: frame_cnt<=1.
  - If MIN_FILL==1 or s_axis_tlast, go to READY; otherwise go to FILL.
- State FILL: done=0; frame_cnt += wr. Go to READY next cycle when any of:
  - frame_cnt+wr >= MIN_FILL;
  - wr & s_axis_tlast (short frame);
  - stall_cnt reaches STALL_CYCLES with level>0.
- State READY: done=1.
  - wr & s_axis_tlast sets last_seen.
  - Exit to IDLE when last_seen & (next level == 0) & ~wr. On exit, clear last_seen, frame_cnt and stall_cnt; done falls the same edge.
  - Beats of a following frame that arrive before the FIFO drains stay in READY (continuous stream).
- READY entered via tlast: last_seen is set on entry.
- Latency: done rises on the clock edge after the qualifying write beat (one-cycle registered latency).
- Reset mid-frame clears all state; FIFO contents are not tracked after reset, so the FIFO must be reset by the same rst.

Test Plan:
- Long frame: 20 back-to-back beats, tlast on beat 20, no reads → done rises the edge after beat 8; level=20 after beat 20; done stays 1.
- Drain: from the previous end, hold fifo_rd_enable 20 cycles → level steps down to 0; done falls on the same edge level reaches 0; state=IDLE.
- Short frame: 3 beats, tlast on beat 3 → done=1 the edge after beat 3. Then read 3 → done=0.
- Stall: 4 beats then tvalid low 16 cycles → done rises after the 16th idle cycle; level=4.
- Full/overflow: 32 beats with no reads → fifo_full=1, tready=0. A 33rd tvalid → overflow_sticky=1 and level stays 32. clear_sticky pulse → flag=0.
- Simultaneous and async reset:
  - wr and rd in the same cycle at level=5 → level stays 5.
  - rd at level=0 → underflow_sticky=1.
  - rst asserted mid-READY → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/axis_fifo_prefill_monitor.sv
// Write-side prefill monitor for the TX FIFO.
// It tracks FIFO occupancy and how much of the current frame has been
// written. fifo_min_data_write_done tells the read controller that enough
// data is buffered to start reading without running the FIFO dry. That
// happens after MIN_FILL words, at the end of a short frame, or when the
// source stalls. Done then stays high until the frame has fully drained.
module axis_fifo_prefill_monitor #(
  parameter int DEPTH_LOG2   = 5,
  parameter int MIN_FILL     = 8,
  parameter int STALL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  fifo_rd_enable,
  output logic                  fifo_wr_en,
  output logic                  fifo_min_data_write_done,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  input  logic                  clear_sticky,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(2 ** DEPTH_LOG2);
  localparam logic [CW-1:0] MIN_W   = CW'(MIN_FILL);
  localparam logic [7:0]    STALL_W = 8'(STALL_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]    stall_cnt_q, stall_cnt_d;
  logic          last_seen_q, last_seen_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr;
  logic          rd;
  logic [CW-1:0] frame_sum;
  logic [CW-1:0] frame_sat;
  logic [7:0]    stall_inc;

  // Handshake and status decode derived from the registered level.
  assign fifo_full                = (level_q == DEPTH_W);
  assign fifo_empty               = (level_q == '0);
  assign s_axis_tready            = ~fifo_full;
  assign fifo_wr_en               = s_axis_tvalid & s_axis_tready;
  assign wr                       = fifo_wr_en;
  assign rd                       = fifo_rd_enable & ~fifo_empty;
  assign fifo_level               = level_q;
  assign fifo_min_data_write_done = done_q;
  assign overflow_sticky          = overflow_q;
  assign underflow_sticky         = underflow_q;

  // Next occupancy and sticky error flags. A set beats a clear in the same cycle.
  always_comb begin
    level_d = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    overflow_d  = (s_axis_tvalid & fifo_full)   | (overflow_q  & ~clear_sticky);
    underflow_d = (fifo_rd_enable & fifo_empty) | (underflow_q & ~clear_sticky);
  end

  // Saturating frame and stall counters shared by the FSM below.
  always_comb begin
    frame_sum = frame_cnt_q + (wr ? CW'(1) : CW'(0));
    frame_sat = (frame_sum >= MIN_W) ? MIN_W : frame_sum;
    if (wr) begin
      stall_inc = 8'd0;
    end else if (stall_cnt_q >= STALL_W) begin
      stall_inc = STALL_W;
    end else begin
      stall_inc = stall_cnt_q + 8'd1;
    end
  end

  // Prefill FSM: next state, counter updates and the done flag.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    last_seen_d = last_seen_q;
    case (state_q)
      S_IDLE: begin
        stall_cnt_d = 8'd0;
        last_seen_d = 1'b0;
        if (wr) begin
          frame_cnt_d = CW'(1);
          if ((MIN_FILL == 1) || s_axis_tlast) begin
            state_d     = S_READY;
            last_seen_d = s_axis_tlast;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        frame_cnt_d = frame_sat;
        stall_cnt_d = stall_inc;
        // A stall only counts while something is actually buffered.
        if ((frame_sum >= MIN_W) || (wr & s_axis_tlast) ||
            ((stall_inc == STALL_W) && (level_d != '0))) begin
          state_d     = S_READY;
          last_seen_d = wr & s_axis_tlast;
        end
      end
      S_READY: begin
        frame_cnt_d = frame_sat;
        stall_cnt_d = stall_inc;
        if (wr & s_axis_tlast) begin
          last_seen_d = 1'b1;
        end
        // Beats of a following frame keep us here until the FIFO empties.
        if (last_seen_q && (level_d == '0) && !wr) begin
          state_d     = S_IDLE;
          last_seen_d = 1'b0;
          frame_cnt_d = '0;
          stall_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        frame_cnt_d = '0;
        stall_cnt_d = 8'd0;
        last_seen_d = 1'b0;
      end
    endcase
    done_d = (state_d == S_READY);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      frame_cnt_q <= '0;
      stall_cnt_q <= 8'd0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      last_seen_q <= last_seen_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_axis_fifo_prefill_monitor.sv
// Bench for axis_fifo_prefill_monitor: directed sequences, a vector table
// and randomized traffic checked against a frame-level reference model.
module tb_axis_fifo_prefill_monitor;

  localparam int DL = 5;
  localparam int MF = 8;
  localparam int SC = 16;
  localparam int D  = 2 ** DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          tvalid, tlast, tready, rd, wr_en, done, full, empty, clr, ovf, udf;
  logic [DL:0]   level;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: occupancy, words in current frame, idle run,
  // whether a frame is being collected / released, and whether its end arrived.
  int m_lvl, m_fill, m_idle;
  bit m_collect, m_release, m_ended, m_ovf, m_udf;

  typedef struct {
    logic v, l, r, c;
    int   exp_level;
    logic exp_done, exp_ovf, exp_udf;
  } vec_t;
  vec_t vecs[$];

  axis_fifo_prefill_monitor #(
    .DEPTH_LOG2  (DL),
    .MIN_FILL    (MF),
    .STALL_CYCLES(SC)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .s_axis_tvalid           (tvalid),
    .s_axis_tlast            (tlast),
    .s_axis_tready           (tready),
    .fifo_rd_enable          (rd),
    .fifo_wr_en              (wr_en),
    .fifo_min_data_write_done(done),
    .fifo_level              (level),
    .fifo_full               (full),
    .fifo_empty              (empty),
    .clear_sticky            (clr),
    .overflow_sticky         (ovf),
    .underflow_sticky        (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_fill = 0; m_idle = 0;
    m_collect = 0; m_release = 0; m_ended = 0; m_ovf = 0; m_udf = 0;
  endtask

  // One clock of the reference model, written from the frame rules directly.
  task automatic model_step(input bit v, input bit l, input bit r, input bit c);
    bit m_full, m_empty, w, rdok;
    int nlvl;
    m_full  = (m_lvl == D);
    m_empty = (m_lvl == 0);
    w       = v && !m_full;
    rdok    = r && !m_empty;
    nlvl    = m_lvl + int'(w) - int'(rdok);
    m_ovf   = (v && m_full) || (m_ovf && !c);
    m_udf   = (r && m_empty) || (m_udf && !c);
    if (!m_collect && !m_release) begin
      if (w) begin
        m_fill = 1;
        m_idle = 0;
        if (MF == 1 || l) begin
          m_release = 1;
          m_ended   = l;
        end else begin
          m_collect = 1;
        end
      end
    end else if (m_collect) begin
      if (w) begin
        m_fill++;
        m_idle = 0;
      end else if (m_idle < SC) begin
        m_idle++;
      end
      if (m_fill >= MF || (w && l) || (m_idle >= SC && nlvl > 0)) begin
        m_collect = 0;
        m_release = 1;
        m_ended   = w && l;
      end
    end else begin
      if (m_ended && nlvl == 0 && !w) begin
        m_release = 0;
        m_ended   = 0;
        m_fill    = 0;
        m_idle    = 0;
      end else if (w && l) begin
        m_ended = 1;
      end
    end
    m_lvl = nlvl;
  endtask

  // Drive one cycle of inputs, advance the model, and wait past the edge.
  task automatic cycle(input logic v, input logic l, input logic r, input logic c);
    tvalid = v; tlast = l; rd = r; clr = c;
    model_step(v, l, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tvalid = 0; tlast = 0; rd = 0; clr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},  int'(level),  0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_tready"}, int'(tready), 1);
    check({tag, "_full"},   int'(full),   0);
    check({tag, "_empty"},  int'(empty),  1);
    check({tag, "_ovf"},    int'(ovf),    0);
    check({tag, "_udf"},    int'(udf),    0);
  endtask

  task automatic add(input logic v, input logic l, input logic r, input logic c,
                     input int lv, input logic dn, input logic ov, input logic ud);
    vec_t e;
    e.v = v; e.l = l; e.r = r; e.c = c;
    e.exp_level = lv; e.exp_done = dn; e.exp_ovf = ov; e.exp_udf = ud;
    vecs.push_back(e);
  endtask

  initial begin
    // Exact MIN_FILL frame with tlast, overlapping next-frame beat, drain,
    // underflow, clear, and a single-beat frame.
    for (int i = 1; i <= 7; i++) add(1, 0, 0, 0, i, 0, 0, 0);
    add(1, 1, 0, 0, 8, 1, 0, 0);
    add(0, 0, 1, 0, 7, 1, 0, 0);
    add(1, 0, 1, 0, 7, 1, 0, 0);
    for (int i = 6; i >= 1; i--) add(0, 0, 1, 0, i, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; tvalid = 0; tlast = 0; rd = 0; clr = 0;
    #12;
    check_reset_values("reset");
    apply_reset();
    check_reset_values("reset_rel");

    // Long frame: done rises the edge after beat MIN_FILL.
    for (int i = 1; i <= 20; i++) begin
      cycle(1, (i == 20), 0, 0);
      if (i == MF - 1) check("long_done_early", int'(done), 0);
      if (i == MF)     check("long_done_rise", int'(done), 1);
    end
    check("long_level", int'(level), 20);
    check("long_done_hold", int'(done), 1);
    $display("long frame: level=%0d done=%0d", level, done);

    // Drain: done falls on the edge the level reaches zero.
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 1, 0);
      if (i == 19) begin
        check("drain_level_1", int'(level), 1);
        check("drain_done_1", int'(done), 1);
      end
    end
    check("drain_level_0", int'(level), 0);
    check("drain_done_0", int'(done), 0);
    check("drain_empty", int'(empty), 1);
    $display("drain: level=%0d done=%0d", level, done);

    // Short frame.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("short_done_pre", int'(done), 0);
    cycle(1, 1, 0, 0);
    check("short_done", int'(done), 1);
    check("short_level", int'(level), 3);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check("short_done_mid", int'(done), 1);
    cycle(0, 0, 1, 0);
    check("short_done_fall", int'(done), 0);
    $display("short frame: done=%0d level=%0d", done, level);

    // Stall.
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    for (int i = 1; i <= SC; i++) begin
      cycle(0, 0, 0, 0);
      if (i == SC - 1) check("stall_done_early", int'(done), 0);
    end
    check("stall_done", int'(done), 1);
    check("stall_level", int'(level), 4);
    $display("stall: done=%0d level=%0d", done, level);

    // Full and overflow.
    apply_reset();
    for (int i = 0; i < D; i++) cycle(1, 0, 0, 0);
    tvalid = 1; tlast = 0; rd = 0; clr = 0;
    #1;
    check("full_flag", int'(full), 1);
    check("full_tready", int'(tready), 0);
    check("full_wr_en", int'(wr_en), 0);
    cycle(1, 0, 0, 0);
    check("ovf_set", int'(ovf), 1);
    check("ovf_level", int'(level), D);
    cycle(0, 0, 0, 1);
    check("ovf_clear", int'(ovf), 0);
    $display("overflow: level=%0d full=%0d", level, full);

    // Simultaneous write and read.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check("simul_level", int'(level), 5);

    // Underflow, with set beating clear.
    apply_reset();
    cycle(0, 0, 1, 0);
    check("udf_set", int'(udf), 1);
    check("udf_level", int'(level), 0);
    cycle(0, 0, 1, 1);
    check("udf_set_over_clr", int'(udf), 1);
    cycle(0, 0, 0, 1);
    check("udf_clear", int'(udf), 0);
    $display("underflow: udf=%0d", udf);

    // Asynchronous reset in READY.
    cycle(1, 1, 0, 0);
    check("areset_pre_done", int'(done), 1);
    rst = 1'b1;
    tvalid = 0; tlast = 0; rd = 0; clr = 0;
    #2;
    check_reset_values("areset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("async reset: done=%0d level=%0d", done, level);

    // Vector table.
    apply_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
      check($sformatf("vec%0d_done", i),  int'(done),  int'(vecs[i].exp_done));
      check($sformatf("vec%0d_ovf", i),   int'(ovf),   int'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_udf", i),   int'(udf),   int'(vecs[i].exp_udf));
      $display("vec %0d: v=%0b l=%0b r=%0b c=%0b level=%0d done=%0b",
               i, vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].c, level, done);
    end

    // Randomized traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      logic v, l, r, c;
      int rd_pct;
      rd_pct = ((n / 250) % 2 == 0) ? 30 : 65;
      v = ($urandom_range(99) < 60);
      l = ($urandom_range(11) == 0);
      r = ($urandom_range(99) < rd_pct);
      c = ($urandom_range(31) == 0);
      tvalid = v; tlast = l; rd = r; clr = c;
      #1;
      check("rnd_full",   int'(full),   int'(m_lvl == D));
      check("rnd_empty",  int'(empty),  int'(m_lvl == 0));
      check("rnd_tready", int'(tready), int'(m_lvl != D));
      check("rnd_wr_en",  int'(wr_en),  int'(v && (m_lvl != D)));
      model_step(v, l, r, c);
      @(posedge clk);
      #1;
      check("rnd_level", int'(level), m_lvl);
      check("rnd_done",  int'(done),  int'(m_release));
      check("rnd_ovf",   int'(ovf),   int'(m_ovf));
      check("rnd_udf",   int'(udf),   int'(m_udf));
      if (n % 500 == 499) $display("random batch to %0d: level=%0d done=%0b", n + 1, level, done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
